// File: rtl/jt51_acc_pkg.sv
// jt51 accumulator shared defs: slot group codes,
// carrier-enable decode and generic signed saturation.
package jt51_acc_pkg;

  localparam logic [1:0] GRP_M1 = 2'd0;
  localparam logic [1:0] GRP_M2 = 2'd1;
  localparam logic [1:0] GRP_C1 = 2'd2;
  localparam logic [1:0] GRP_C2 = 2'd3;

  function automatic logic car_en(
    input logic [2:0] con,
    input logic [1:0] grp
  );
    logic en;
    en = 1'b0;
    case (con)
      3'd4:       en = (grp == GRP_C1) || (grp == GRP_C2);
      3'd5, 3'd6: en = (grp != GRP_M1);
      3'd7:       en = 1'b1;
      default:    en = (grp == GRP_C2);
    endcase
    return en;
  endfunction

  function automatic logic signed [31:0] sat(
    input logic signed [31:0] v,
    input int                 w
  );
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic is_clip(
    input logic signed [31:0] v,
    input int                 w
  );
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    return (v > hi) || (v < lo);
  endfunction

endpackage

// File: rtl/jt51_acc_chsum.sv
// Per-channel operator sum store (CH deep) with saturating add.
// In: clk rst cen grp ch en op_val. Out: sum (channel total this slot).
module jt51_acc_chsum #(
  parameter int CH   = 8,
  parameter int ACCW = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cen,
  input  logic [1:0]               grp,
  input  logic [$clog2(CH)-1:0]    ch,
  input  logic                     en,
  input  logic signed [ACCW-1:0]   op_val,
  output logic signed [ACCW-1:0]   sum
);
  import jt51_acc_pkg::*;

  logic signed [ACCW-1:0] mem_q [CH];
  logic signed [ACCW-1:0] mem_d [CH];
  logic signed [ACCW-1:0] add;
  logic signed [31:0]     wide;

  always_comb begin
    add  = en ? op_val : '0;
    wide = 32'(mem_q[ch]) + 32'(add);
    // M1 starts a fresh sum for the channel
    if (grp == GRP_M1) sum = add;
    else               sum = ACCW'(sat(wide, ACCW));
  end

  always_comb begin
    mem_d = mem_q;
    if (cen) mem_d[ch] = sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      foreach (mem_q[i]) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/jt51_acc_mix.sv
// jt51 operator accumulator + stereo mixer; slot tracking from sync,
// pan/mute mix, saturated L/R, sample_stb, locked. Clip flags: JT51_ACC_CLIPDET_EN.
module jt51_acc_mix #(
  parameter int CH   = 8,
  parameter int OPW  = 14,
  parameter int ACCW = 16,
  parameter int OUTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic            sync,
  input  logic [OPW-1:0]  op_out,
  input  logic [2:0]      con,
  input  logic [1:0]      rl,
  input  logic            ne,
  input  logic [11:0]     noise_mix,
  input  logic [CH-1:0]   mute,
  input  logic            clip_clr,
  output logic [OUTW-1:0] left,
  output logic [OUTW-1:0] right,
  output logic            sample_stb,
  output logic            locked,
  output logic            clip_l,
  output logic            clip_r
);
  import jt51_acc_pkg::*;

  localparam int CW = $clog2(CH);
  localparam int SW = CW + 2;
  localparam int FW = ACCW + CW;
  localparam logic [SW-1:0] LAST = SW'(4 * CH - 1);
  localparam logic [SW-1:0] C2_0 = SW'(3 * CH);

  logic [SW-1:0]          slot_q, slot_d, cur;
  logic [1:0]             grp;
  logic [CW-1:0]          ch;
  logic                   en, brk, last;
  logic signed [ACCW-1:0] op_val, ch_tot;
  logic signed [FW-1:0]   accl_q, accl_d, accr_q, accr_d;
  logic signed [FW-1:0]   add_l, add_r;
  logic signed [31:0]     wl, wr;
  logic [OUTW-1:0]        left_q, left_d, right_q, right_d;
  logic                   locked_q, locked_d;
  logic                   synced_q, synced_d;
  logic                   stb_q, stb_d;
  logic                   sat_l, sat_r;

  // sync re-labels the slot presented this cycle as slot 0
  assign cur    = sync ? '0 : slot_q;
  assign grp    = cur[SW-1 -: 2];
  assign ch     = cur[CW-1:0];
  assign last   = (cur == LAST);
  assign brk    = cen && sync && (slot_q != '0);
  assign en     = car_en(con, grp);
  assign op_val = (ne && last) ? ACCW'(signed'(noise_mix))
                               : ACCW'(signed'(op_out));

  jt51_acc_chsum #(
    .CH   (CH),
    .ACCW (ACCW)
  ) u_chsum (
    .clk    (clk),
    .rst    (rst),
    .cen    (cen),
    .grp    (grp),
    .ch     (ch),
    .en     (en),
    .op_val (op_val),
    .sum    (ch_tot)
  );

  always_comb begin
    add_l  = (!mute[ch] && rl[0]) ? FW'(ch_tot) : '0;
    add_r  = (!mute[ch] && rl[1]) ? FW'(ch_tot) : '0;
    accl_d = accl_q;
    accr_d = accr_q;
    if (brk) begin
      accl_d = '0;
      accr_d = '0;
    end else if (cen && grp == GRP_C2) begin
      if (cur == C2_0) begin
        accl_d = add_l;
        accr_d = add_r;
      end else begin
        accl_d = accl_q + add_l;
        accr_d = accr_q + add_r;
      end
    end
  end

  always_comb begin
    wl      = 32'(accl_d);
    wr      = 32'(accr_d);
    sat_l   = is_clip(wl, OUTW);
    sat_r   = is_clip(wr, OUTW);
    left_d  = left_q;
    right_d = right_q;
    if (cen && last) begin
      left_d  = OUTW'(sat(wl, OUTW));
      right_d = OUTW'(sat(wr, OUTW));
    end
  end

  always_comb begin
    synced_d = synced_q | (cen & sync);
    locked_d = locked_q;
    if (brk)                          locked_d = 1'b0;
    else if (cen && last && synced_q) locked_d = 1'b1;
    stb_d  = cen && last && locked_d;
    slot_d = slot_q;
    if (cen) slot_d = last ? '0 : cur + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q   <= '0;
      accl_q   <= '0;
      accr_q   <= '0;
      left_q   <= '0;
      right_q  <= '0;
      locked_q <= 1'b0;
      synced_q <= 1'b0;
      stb_q    <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      accl_q   <= accl_d;
      accr_q   <= accr_d;
      left_q   <= left_d;
      right_q  <= right_d;
      locked_q <= locked_d;
      synced_q <= synced_d;
      stb_q    <= stb_d;
    end
  end

  assign left       = left_q;
  assign right      = right_q;
  assign locked     = locked_q;
  assign sample_stb = stb_q;

`ifdef JT51_ACC_CLIPDET_EN
  logic clip_l_q, clip_l_d, clip_r_q, clip_r_d;

  // a new clip beats a simultaneous clear
  always_comb begin
    clip_l_d = clip_l_q;
    clip_r_d = clip_r_q;
    if (cen && clip_clr) begin
      clip_l_d = 1'b0;
      clip_r_d = 1'b0;
    end
    if (cen && last && sat_l) clip_l_d = 1'b1;
    if (cen && last && sat_r) clip_r_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clip_l_q <= 1'b0;
      clip_r_q <= 1'b0;
    end else begin
      clip_l_q <= clip_l_d;
      clip_r_q <= clip_r_d;
    end
  end

  assign clip_l = clip_l_q;
  assign clip_r = clip_r_q;
`else
  logic unused_clip;
  assign unused_clip = ^{clip_clr, sat_l, sat_r};
  assign clip_l      = 1'b0;
  assign clip_r      = 1'b0;
`endif

endmodule
